// File: rtl/groestl_pkg.sv
// Shared Grøstl-256 constants: FSM encodings, IV, permutation modes and the
// byte-level GF(2^8) helpers used by the round logic.
package groestl_pkg;

  localparam int ROUNDS = 10;

  localparam logic MODE_P = 1'b1;
  localparam logic MODE_Q = 1'b0;

  // Output length (256) encoded big-endian in the last two bytes
  localparam logic [511:0] GROESTL256_IV = 512'h0100;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_PRND = 3'd1;
  localparam state_t S_QRND = 3'd2;
  localparam state_t S_FOLD = 3'd3;
  localparam state_t S_OUTP = 3'd4;
  localparam state_t S_DONE = 3'd5;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // MixBytes coefficients never exceed 7, so three partial products suffice
  function automatic logic [7:0] mulc(input logic [7:0] x, input logic [2:0] k);
    logic [7:0] x2, x4;
    x2 = xtime(x);
    x4 = xtime(x2);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00);
  endfunction

endpackage

// File: rtl/groestl_compress_if.sv
// Block-in / digest-out bus of the Grøstl-256 compression engine.
interface groestl_compress_if;
  logic         init;
  logic         msg_valid;
  logic         msg_ready;
  logic [511:0] msg;
  logic         msg_last;
  logic         hash_valid;
  logic [255:0] hash;
  logic         busy;

  modport master (
    output init, msg_valid, msg, msg_last,
    input  msg_ready, hash_valid, hash, busy
  );

  modport slave (
    input  init, msg_valid, msg, msg_last,
    output msg_ready, hash_valid, hash, busy
  );
endinterface

// File: rtl/groestl_compress_permute.sv
// One combinational Grøstl-512-bit-state round (AddRoundConstant, SubBytes,
// ShiftBytes, MixBytes) for either P (mode=1) or Q (mode=0).
module groestl_compress_permute
  import groestl_pkg::*;
(
  input  logic [511:0] st,
  input  logic [7:0]   rnd,
  input  logic         mode,
  output logic [511:0] nxt
);

  localparam logic [0:7][2:0] MIXC = {3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd5, 3'd7};
  localparam logic [0:7][2:0] SHP  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [0:7][2:0] SHQ  = {3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};

  // Byte (row r, column c) of the state is message byte 8*c + r
  logic [7:0] sb [8][8];

  always_comb begin
    logic [7:0] b, k;
    b = 8'h00;
    k = 8'h00;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        b = st[511 - 8*(8*c + r) -: 8];
        k = 8'(c << 4) ^ rnd;
        if (mode == MODE_P) begin
          if (r == 0) b = b ^ k;
        end else begin
          b = b ^ 8'hff ^ ((r == 7) ? k : 8'h00);
        end
        sb[r][c] = sbox(b);
      end
    end
  end

  always_comb begin
    logic [7:0] acc;
    logic [2:0] sh, col;
    nxt = '0;
    acc = 8'h00;
    sh  = 3'd0;
    col = 3'd0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        acc = 8'h00;
        for (int k2 = 0; k2 < 8; k2++) begin
          sh  = (mode == MODE_P) ? SHP[k2] : SHQ[k2];
          col = 3'(c) + sh;
          acc = acc ^ mulc(sb[k2][col], MIXC[3'(k2 - r)]);
        end
        nxt[511 - 8*(8*c + r) -: 8] = acc;
      end
    end
  end

endmodule

// File: rtl/groestl_compress.sv
// Iterative Grøstl-256 compression and output transformation; one shared
// P/Q round per clock, state and round counter owned here.
module groestl_compress
  import groestl_pkg::*;
#(
  parameter int ROUNDS = groestl_pkg::ROUNDS
) (
  input  logic              clk,
  input  logic              rst,
  groestl_compress_if.slave bus
);

  state_t       state;
  logic [511:0] h, ps, qs, pin, pout, hn;
  logic [3:0]   rc;
  logic         last_q, pmode, rnd_end, hvld;
  logic [255:0] hash_r;

  assign pin     = (state == S_QRND) ? qs : ps;
  assign pmode   = (state == S_QRND) ? MODE_Q : MODE_P;
  assign rnd_end = (rc == 4'(ROUNDS - 1));
  assign hn      = h ^ ps ^ qs;

  groestl_compress_permute u_perm (
    .st   (pin),
    .rnd  ({4'b0, rc}),
    .mode (pmode),
    .nxt  (pout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      h      <= GROESTL256_IV;
      ps     <= '0;
      qs     <= '0;
      rc     <= '0;
      last_q <= 1'b0;
      hash_r <= '0;
      hvld   <= 1'b0;
    end else begin
      hvld <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          // An accepted block wins over a simultaneous init
          if (bus.msg_valid) begin
            ps     <= h ^ bus.msg;
            qs     <= bus.msg;
            last_q <= bus.msg_last;
            rc     <= '0;
            state  <= S_PRND;
          end else if (bus.init) begin
            h <= GROESTL256_IV;
          end
        end
        S_PRND, S_OUTP: begin
          ps <= pout;
          rc <= rnd_end ? 4'd0 : rc + 4'd1;
          if (rnd_end) state <= (state == S_PRND) ? S_QRND : S_DONE;
        end
        S_QRND: begin
          qs <= pout;
          rc <= rnd_end ? 4'd0 : rc + 4'd1;
          if (rnd_end) state <= S_FOLD;
        end
        S_FOLD: begin
          h <= hn;
          if (last_q) begin
            ps    <= hn;
            rc    <= '0;
            state <= S_OUTP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          hash_r <= ps[255:0] ^ h[255:0];
          h      <= GROESTL256_IV;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.msg_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.hash_valid = hvld;
  assign bus.hash       = hash_r;

endmodule

// File: tb/tb_groestl_compress.sv
// Directed bench for groestl_compress: KAT, reset abort, back-pressure,
// init handling, two-block and back-to-back digests against a byte model.
`timescale 1ns/1ps
module tb_groestl_compress;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  groestl_compress_if bus();
  groestl_compress dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [511:0] KAT_BLK = {8'h80, 440'h0, 64'h1};
  localparam logic [255:0] KAT_HASH =
    256'h1a52d11d550039be16107f9c58db9ebcc417f16f736adb2502567119f0083467;
  localparam logic [511:0] IV = 512'h0100;

  int tests = 0;
  int fails = 0;
  logic [7:0] msb [256];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [511:0] m_perm(input logic [511:0] x, input bit isq);
    logic [7:0] s [64];
    logic [7:0] t [64];
    logic [7:0] acc;
    logic [511:0] y;
    int qsh [8];
    int mc [8];
    qsh = '{1, 3, 5, 7, 0, 2, 4, 6};
    mc  = '{2, 2, 3, 4, 5, 3, 5, 7};
    for (int k = 0; k < 64; k++) s[k] = x[511 - 8*k -: 8];
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (!isq) s[8*j] = s[8*j] ^ 8'(16*j + i);
        else begin
          for (int r = 0; r < 7; r++) s[8*j + r] = s[8*j + r] ^ 8'hff;
          s[8*j + 7] = s[8*j + 7] ^ 8'hff ^ 8'(16*j + i);
        end
      end
      for (int k = 0; k < 64; k++) s[k] = msb[s[k]];
      for (int j = 0; j < 8; j++)
        for (int r = 0; r < 8; r++)
          t[8*j + r] = s[8*((j + (isq ? qsh[r] : r)) % 8) + r];
      for (int j = 0; j < 8; j++)
        for (int r = 0; r < 8; r++) begin
          acc = 8'h00;
          for (int k = 0; k < 8; k++)
            acc = acc ^ m_mul(t[8*j + k], 8'(mc[(k - r + 8) % 8]));
          s[8*j + r] = acc;
        end
    end
    for (int k = 0; k < 64; k++) y[511 - 8*k -: 8] = s[k];
    return y;
  endfunction

  function automatic logic [511:0] m_compress(input logic [511:0] hv, input logic [511:0] m);
    return m_perm(hv ^ m, 1'b0) ^ m_perm(m, 1'b1) ^ hv;
  endfunction

  function automatic logic [255:0] m_out(input logic [511:0] hv);
    logic [511:0] f;
    f = m_perm(hv, 1'b0) ^ hv;
    return f[255:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [511:0] m, input logic last);
    bus.msg       = m;
    bus.msg_last  = last;
    bus.msg_valid = 1'b1;
    @(negedge clk);
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.msg       = ~m;
  endtask

  task automatic wait_hash(input string tag, input int start, input logic [255:0] exp);
    int cyc;
    cyc = start;
    while (bus.hash_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " valid"}, 512'(bus.hash_valid), 512'(1));
    chk({tag, " latency"}, 512'(cyc), 512'(33));
    chk({tag, " digest"}, 512'(bus.hash), 512'(exp));
  endtask

  task automatic wait_ready(input string tag, input int start);
    int cyc;
    cyc = start;
    while (bus.msg_ready !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " ready cycle"}, 512'(cyc), 512'(22));
  endtask

  logic [1023:0] pm;
  logic [511:0]  blk1, blk2, hmod;
  logic [255:0]  exp2;
  int acc_n, bad_n;
  logic seen;

  initial begin
    #2000000;
    $display("FAIL timeout: observed still running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = m_mul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      msb[x] = b;
    end

    pm = '0;
    for (int i = 0; i < 70; i++) pm[1023 - 8*i -: 8] = 8'(37*i + 5);
    pm[1023 - 8*70 -: 8] = 8'h80;
    pm[63:0] = 64'd2;
    blk1 = pm[1023:512];
    blk2 = pm[511:0];
    hmod = m_compress(IV, blk1);
    hmod = m_compress(hmod, blk2);
    exp2 = m_out(hmod);

    rst = 1'b1;
    bus.init = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_last = 1'b0;
    bus.msg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset msg_ready", 512'(bus.msg_ready), 512'(1));
    chk("reset busy", 512'(bus.busy), 512'(0));
    chk("reset hash_valid", 512'(bus.hash_valid), 512'(0));
    chk("reset hash", 512'(bus.hash), 512'(0));
    @(negedge clk);

    // Empty-message KAT
    send(KAT_BLK, 1'b1);
    chk("kat busy", 512'(bus.busy), 512'(1));
    chk("kat ready low", 512'(bus.msg_ready), 512'(0));
    wait_hash("kat", 1, KAT_HASH);
    @(negedge clk);
    chk("kat pulse width", 512'(bus.hash_valid), 512'(0));
    chk("kat hash hold", 512'(bus.hash), 512'(KAT_HASH));

    // Reset in the middle of QRND
    send(KAT_BLK, 1'b1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort msg_ready", 512'(bus.msg_ready), 512'(1));
    chk("abort busy", 512'(bus.busy), 512'(0));
    chk("abort hash_valid", 512'(bus.hash_valid), 512'(0));
    chk("abort hash cleared", 512'(bus.hash), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hash_valid === 1'b1) seen = 1'b1;
    end
    chk("abort no hash_valid", 512'(seen), 512'(0));
    send(KAT_BLK, 1'b1);
    wait_hash("kat after abort", 1, KAT_HASH);
    @(negedge clk);

    // Back-pressure: msg_valid held high across three non-last blocks
    bus.msg = blk1;
    bus.msg_last = 1'b0;
    bus.msg_valid = 1'b1;
    acc_n = 0;
    bad_n = 0;
    for (int c = 0; c < 66; c++) begin
      if (bus.msg_ready === 1'b1) acc_n++;
      if (bus.msg_ready !== ((c % 22) == 0)) bad_n++;
      @(negedge clk);
    end
    bus.msg_valid = 1'b0;
    chk("bp accept count", 512'(acc_n), 512'(3));
    chk("bp ready pattern errors", 512'(bad_n), 512'(0));

    // init in IDLE restores the IV
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    send(KAT_BLK, 1'b1);
    wait_hash("kat after init", 1, KAT_HASH);
    @(negedge clk);

    // Two-block message, init pulsed while the second block is in PRND
    send(blk1, 1'b0);
    wait_ready("2blk", 1);
    chk("2blk hash hold", 512'(bus.hash), 512'(KAT_HASH));
    send(blk2, 1'b1);
    @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    wait_hash("2blk", 3, exp2);

    // Back-to-back: next message accepted in the hash_valid cycle
    chk("b2b ready with hash_valid", 512'(bus.msg_ready), 512'(1));
    send(KAT_BLK, 1'b1);
    chk("b2b pulse width", 512'(bus.hash_valid), 512'(0));
    chk("b2b hash hold", 512'(bus.hash), 512'(exp2));
    wait_hash("b2b", 1, KAT_HASH);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
